// File: rtl/heartaware_ui_fsm.sv
// HeartAware UI controller: button edge detection, saturating volume, tick generator and
// the IDLE/ACQUIRE/DISPLAY/ALARM state machine driving LED, siren, BPM and countdown.
module heartaware_ui_fsm #(
  parameter int unsigned TICK_CYCLES   = 25_000_000,
  parameter int unsigned VOL_WIDTH     = 4,
  parameter int unsigned VOL_DEFAULT   = 8,
  parameter int unsigned MIN_BEATS     = 4,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned BPM_LOW       = 40,
  parameter int unsigned BPM_HIGH      = 180
) (
  input  logic                 clock_25mhz,
  input  logic                 reset_n,
  input  logic                 btn_start,
  input  logic                 btn_stop,
  input  logic                 btn_vol_up,
  input  logic                 btn_vol_down,
  input  logic                 beat_valid,
  input  logic [7:0]           bpm,
  output logic [1:0]           fsm_state,
  output logic                 status_indicator,
  output logic                 siren_enable,
  output logic [VOL_WIDTH-1:0] volume,
  output logic [7:0]           bpm_display,
  output logic [7:0]           seconds_left
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0]      TickLast = CntW'(TICK_CYCLES - 1);
  localparam logic [7:0]           Timeout  = 8'(TIMEOUT_TICKS);
  localparam logic [3:0]           MinBeats = 4'(MIN_BEATS);
  localparam logic [7:0]           BpmLow   = 8'(BPM_LOW);
  localparam logic [7:0]           BpmHigh  = 8'(BPM_HIGH);
  localparam logic [VOL_WIDTH-1:0] VolMax   = {VOL_WIDTH{1'b1}};
  localparam logic [VOL_WIDTH-1:0] VolDef   = VOL_WIDTH'(VOL_DEFAULT);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StDisplay = 2'd2,
    StAlarm   = 2'd3
  } state_e;

  state_e              state_q;
  logic                status_q;
  logic                siren_q;
  logic [VOL_WIDTH-1:0] vol_q;
  logic [7:0]          bpm_q;
  logic [7:0]          sec_q;
  logic [3:0]          beats_q;
  logic [CntW-1:0]     tick_cnt_q;
  logic                start_prev_q, stop_prev_q, up_prev_q, down_prev_q;

  logic       start_press, stop_press, up_press, down_press;
  logic       tick, expiry, out_of_range;
  logic [3:0] beats_inc;

  assign start_press  = btn_start & ~start_prev_q;
  assign stop_press   = btn_stop & ~stop_prev_q;
  assign up_press     = btn_vol_up & ~up_prev_q;
  assign down_press   = btn_vol_down & ~down_prev_q;
  assign tick         = (tick_cnt_q == TickLast);
  assign expiry       = tick && (sec_q == 8'd1) && (state_q != StAlarm);
  assign out_of_range = (bpm < BpmLow) || (bpm > BpmHigh);
  assign beats_inc    = beats_q + 4'd1;

  assign fsm_state        = state_q;
  assign status_indicator = status_q;
  assign siren_enable     = siren_q;
  assign volume           = vol_q;
  assign bpm_display      = bpm_q;
  assign seconds_left     = sec_q;

  // Previous levels reset high so a button held through reset is not seen as a press.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      up_prev_q    <= 1'b1;
      down_prev_q  <= 1'b1;
    end else begin
      start_prev_q <= btn_start;
      stop_prev_q  <= btn_stop;
      up_prev_q    <= btn_vol_up;
      down_prev_q  <= btn_vol_down;
    end
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      vol_q <= VolDef;
    end else if (up_press && !down_press && (vol_q != VolMax)) begin
      vol_q <= vol_q + VOL_WIDTH'(1);
    end else if (down_press && !up_press && (vol_q != '0)) begin
      vol_q <= vol_q - VOL_WIDTH'(1);
    end
  end

  // Priority: stop > start > timeout expiry > beat > tick decrement.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      status_q <= 1'b0;
      siren_q  <= 1'b0;
      bpm_q    <= '0;
      sec_q    <= '0;
      beats_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_press && !stop_press) begin
            state_q  <= StAcquire;
            sec_q    <= Timeout;
            beats_q  <= '0;
            status_q <= 1'b1;
          end
        end
        default: begin
          if (stop_press) begin
            state_q  <= StIdle;
            sec_q    <= '0;
            status_q <= 1'b0;
            siren_q  <= 1'b0;
          end else if (start_press) begin
            state_q  <= StAcquire;
            sec_q    <= Timeout;
            beats_q  <= '0;
            status_q <= 1'b1;
            siren_q  <= 1'b0;
          end else if (expiry) begin
            if (state_q == StAcquire) begin
              state_q  <= StIdle;
              sec_q    <= '0;
              status_q <= 1'b0;
            end else begin
              state_q  <= StAcquire;
              sec_q    <= Timeout;
              beats_q  <= '0;
              status_q <= 1'b1;
            end
          end else if (beat_valid) begin
            case (state_q)
              StAcquire: begin
                beats_q <= beats_inc;
                sec_q   <= Timeout;
                if (beats_inc == MinBeats) begin
                  state_q  <= StDisplay;
                  bpm_q    <= bpm;
                  status_q <= 1'b1;
                end else if (tick) begin
                  status_q <= ~status_q;
                end
              end
              StDisplay: begin
                bpm_q <= bpm;
                sec_q <= Timeout;
                if (out_of_range) begin
                  state_q  <= StAlarm;
                  status_q <= 1'b1;
                  siren_q  <= 1'b1;
                end
              end
              default: begin
                bpm_q <= bpm;
                if (tick) status_q <= ~status_q;
              end
            endcase
          end else if (tick) begin
            if (state_q != StAlarm) sec_q <= sec_q - 8'd1;
            if (state_q != StDisplay) status_q <= ~status_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heartaware_ui_fsm.sv
// Scoreboard bench for heartaware_ui_fsm: directed scenarios plus random stimulus, each cycle's
// expected outputs come from a rule-level reference model and are checked by a separate monitor.
module tb_heartaware_ui_fsm;

  localparam int TICK = 4;
  localparam int TO   = 3;
  localparam int MINB = 2;
  localparam int LOW  = 40;
  localparam int HIGH = 180;
  localparam int VMAX = 15;
  localparam int VDEF = 8;

  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_STOP  = 4'b0100;
  localparam logic [3:0] B_UP    = 4'b0010;
  localparam logic [3:0] B_DN    = 4'b0001;

  logic       clock_25mhz = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_vol_up = 1'b0, btn_vol_down = 1'b0;
  logic       beat_valid = 1'b0;
  logic [7:0] bpm = 8'd0;
  logic [1:0] fsm_state;
  logic       status_indicator, siren_enable;
  logic [3:0] volume;
  logic [7:0] bpm_display, seconds_left;

  heartaware_ui_fsm #(
    .TICK_CYCLES  (TICK),
    .VOL_WIDTH    (4),
    .VOL_DEFAULT  (VDEF),
    .MIN_BEATS    (MINB),
    .TIMEOUT_TICKS(TO),
    .BPM_LOW      (LOW),
    .BPM_HIGH     (HIGH)
  ) dut (
    .clock_25mhz     (clock_25mhz),
    .reset_n         (reset_n),
    .btn_start       (btn_start),
    .btn_stop        (btn_stop),
    .btn_vol_up      (btn_vol_up),
    .btn_vol_down    (btn_vol_down),
    .beat_valid      (beat_valid),
    .bpm             (bpm),
    .fsm_state       (fsm_state),
    .status_indicator(status_indicator),
    .siren_enable    (siren_enable),
    .volume          (volume),
    .bpm_display     (bpm_display),
    .seconds_left    (seconds_left)
  );

  always #5 clock_25mhz = ~clock_25mhz;

  typedef struct {
    int st;
    int led;
    int siren;
    int vol;
    int bpmd;
    int sec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Reference model state (state numbering as seen on fsm_state).
  int m_st, m_sec, m_beats, m_bpm, m_led, m_vol, m_cyc;
  bit p_start, p_stop, p_up, p_dn;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sec = 0; m_beats = 0; m_bpm = 0; m_led = 0; m_vol = VDEF; m_cyc = 0;
    p_start = 1; p_stop = 1; p_up = 1; p_dn = 1;
  endtask

  task automatic model_step(input logic [3:0] btn, input bit bv, input int b);
    bit tick, ps, pp, pu, pd, entered, expiry;
    tick = (m_cyc % TICK) == TICK - 1;
    m_cyc++;
    ps = btn[3] && !p_start;
    pp = btn[2] && !p_stop;
    pu = btn[1] && !p_up;
    pd = btn[0] && !p_dn;
    p_start = btn[3]; p_stop = btn[2]; p_up = btn[1]; p_dn = btn[0];
    if (pu && !pd && m_vol < VMAX) m_vol++;
    if (pd && !pu && m_vol > 0) m_vol--;
    entered = 0;
    expiry = tick && m_sec == 1 && (m_st == 1 || m_st == 2);
    if (m_st == 0) begin
      if (ps && !pp) begin m_st = 1; m_sec = TO; m_beats = 0; entered = 1; end
    end else if (pp) begin
      m_st = 0; m_sec = 0; entered = 1;
    end else if (ps) begin
      m_st = 1; m_sec = TO; m_beats = 0; entered = 1;
    end else if (expiry) begin
      if (m_st == 1) begin m_st = 0; m_sec = 0; end
      else begin m_st = 1; m_sec = TO; m_beats = 0; end
      entered = 1;
    end else if (bv) begin
      if (m_st == 1) begin
        m_beats++;
        m_sec = TO;
        if (m_beats == MINB) begin m_st = 2; m_bpm = b; entered = 1; end
      end else if (m_st == 2) begin
        m_bpm = b;
        m_sec = TO;
        if (b < LOW || b > HIGH) begin m_st = 3; entered = 1; end
      end else begin
        m_bpm = b;
      end
    end else if (tick && m_st != 3) begin
      m_sec--;
    end
    if (entered) m_led = (m_st != 0);
    else if (tick && (m_st == 1 || m_st == 3)) m_led = !m_led;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic [3:0] btn, input bit bv, input int b);
    exp_t e;
    @(negedge clock_25mhz);
    {btn_start, btn_stop, btn_vol_up, btn_vol_down} = btn;
    beat_valid = bv;
    bpm = 8'(b);
    model_step(btn, bv, b);
    e.st = m_st; e.led = m_led; e.siren = (m_st == 3); e.vol = m_vol;
    e.bpmd = m_bpm; e.sec = m_sec;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] btn);
    cyc(btn, 1'b0, 0);
    cyc(4'b0000, 1'b0, 0);
  endtask

  task automatic release_reset();
    @(posedge clock_25mhz);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(fsm_state), 0);
    chk({tag, "_led"}, int'(status_indicator), 0);
    chk({tag, "_siren"}, int'(siren_enable), 0);
    chk({tag, "_vol"}, int'(volume), VDEF);
    chk({tag, "_bpmd"}, int'(bpm_display), 0);
    chk({tag, "_sec"}, int'(seconds_left), 0);
  endtask

  always @(posedge clock_25mhz) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_state", int'(fsm_state), mon_e.st);
      chk("sb_led", int'(status_indicator), mon_e.led);
      chk("sb_siren", int'(siren_enable), mon_e.siren);
      chk("sb_volume", int'(volume), mon_e.vol);
      chk("sb_bpm_display", int'(bpm_display), mon_e.bpmd);
      chk("sb_seconds_left", int'(seconds_left), mon_e.sec);
    end
  end

  initial begin
    model_reset();
    btn_start = 1'b1;
    repeat (3) @(posedge clock_25mhz);
    #2;
    chk_reset_vals("reset");

    // Start held through reset must not register as a press.
    release_reset();
    cyc(B_START, 1'b0, 0);
    cyc(B_START, 1'b0, 0);
    chk("held_start_idle", int'(fsm_state), 0);
    cyc(4'b0000, 1'b0, 0);
    press(B_START);
    chk("start_acq", int'(fsm_state), 1);
    chk("start_sec", int'(seconds_left), 3);

    cyc(4'b0000, 1'b1, 72);
    cyc(4'b0000, 1'b1, 72);
    cyc(4'b0000, 1'b0, 0);
    chk("disp_state", int'(fsm_state), 2);
    chk("disp_bpm", int'(bpm_display), 72);
    chk("disp_led", int'(status_indicator), 1);
    chk("disp_siren", int'(siren_enable), 0);

    cyc(4'b0000, 1'b1, 200);
    cyc(4'b0000, 1'b0, 0);
    chk("alarm_state", int'(fsm_state), 3);
    chk("alarm_siren", int'(siren_enable), 1);
    chk("alarm_bpm", int'(bpm_display), 200);
    cyc(4'b0000, 1'b1, 80);
    cyc(4'b0000, 1'b0, 0);
    chk("alarm_latched", int'(fsm_state), 3);
    chk("alarm_bpm_upd", int'(bpm_display), 80);
    press(B_STOP);
    chk("stop_idle", int'(fsm_state), 0);
    chk("stop_siren", int'(siren_enable), 0);

    // Silent ACQUIRE times out to IDLE within three ticks.
    press(B_START);
    repeat (16) cyc(4'b0000, 1'b0, 0);
    chk("acq_timeout_state", int'(fsm_state), 0);
    chk("acq_timeout_sec", int'(seconds_left), 0);

    // Silent DISPLAY falls back to ACQUIRE with a fresh countdown.
    press(B_START);
    cyc(4'b0000, 1'b1, 100);
    cyc(4'b0000, 1'b1, 100);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0000, 1'b0, 0);
      if (fsm_state == 2'd1) break;
    end
    chk("disp_timeout_state", int'(fsm_state), 1);
    chk("disp_timeout_sec", int'(seconds_left), 3);
    press(B_STOP);

    repeat (20) press(B_UP);
    chk("vol_sat_hi", int'(volume), 15);
    press(B_UP | B_DN);
    chk("vol_both", int'(volume), 15);
    repeat (16) press(B_DN);
    chk("vol_sat_lo", int'(volume), 0);

    // Beat landing on a tick cycle reloads instead of decrementing.
    press(B_START);
    for (int i = 0; i < TICK && (m_cyc % TICK) != TICK - 1; i++) cyc(4'b0000, 1'b0, 0);
    cyc(4'b0000, 1'b1, 90);
    cyc(4'b0000, 1'b0, 0);
    chk("tick_beat_sec", int'(seconds_left), 3);
    chk("tick_beat_state", int'(fsm_state), 1);

    press(B_STOP);
    press(B_START | B_STOP);
    chk("start_stop_idle", int'(fsm_state), 0);

    // Start in ALARM restarts acquisition.
    press(B_START);
    cyc(4'b0000, 1'b1, 72);
    cyc(4'b0000, 1'b1, 72);
    cyc(4'b0000, 1'b1, 30);
    cyc(4'b0000, 1'b0, 0);
    chk("alarm_low", int'(fsm_state), 3);
    press(B_START);
    chk("alarm_restart", int'(fsm_state), 1);

    // Asynchronous reset while in ALARM.
    cyc(4'b0000, 1'b1, 72);
    cyc(4'b0000, 1'b1, 72);
    cyc(4'b0000, 1'b1, 250);
    @(posedge clock_25mhz);
    #2;
    chk("pre_reset_alarm", int'(fsm_state), 3);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(posedge clock_25mhz);
    release_reset();

    for (int i = 0; i < 800; i++) begin
      logic [3:0] btn;
      bit bv;
      btn[3] = ($urandom_range(0, 15) == 0);
      btn[2] = ($urandom_range(0, 24) == 0);
      btn[1] = ($urandom_range(0, 3) == 0);
      btn[0] = ($urandom_range(0, 4) == 0);
      bv = ($urandom_range(0, 3) == 0);
      cyc(btn, bv, int'($urandom_range(20, 230)));
    end
    cyc(4'b0000, 1'b0, 0);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clock_25mhz);
    #3;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
